// File: rtl/cdb_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cdb_arbiter_if
// Brief    : Result-source handshake and common-data-bus lane bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_SRC  = 6,
    parameter int NUM_LANE = 5
);
    logic                flush;
    logic [NUM_SRC-1:0]  valid_src;
    logic [NUM_SRC-1:0]  RegWr_src;
    logic [5:0]          Pd_src     [NUM_SRC];
    logic [31:0]         Result_src [NUM_SRC];
    logic [NUM_SRC-1:0]  ready_src;
    logic [NUM_LANE-1:0] ready_cdb;
    logic [NUM_LANE-1:0] RegWr_cdb;
    logic [5:0]          Pd_cdb     [NUM_LANE];
    logic [31:0]         Result_cdb [NUM_LANE];

    modport master (
        output flush, valid_src, RegWr_src, Pd_src, Result_src,
        input  ready_src, ready_cdb, RegWr_cdb, Pd_cdb, Result_cdb
    );

    modport slave (
        input  flush, valid_src, RegWr_src, Pd_src, Result_src,
        output ready_src, ready_cdb, RegWr_cdb, Pd_cdb, Result_cdb
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Per-source result FIFOs with round-robin packing onto CDB lanes.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_SRC    = 6,
    parameter int NUM_LANE   = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int c_LIDX_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
    localparam int c_NG_W   = $clog2(NUM_LANE + 1);

    logic [NUM_SRC-1:0]  w_nonempty;
    logic [NUM_SRC-1:0]  w_push;
    logic [NUM_SRC-1:0]  w_grant;
    logic [NUM_SRC-1:0]  w_head_wr;
    logic [5:0]          w_head_pd  [NUM_SRC];
    logic [31:0]         w_head_res [NUM_SRC];

    logic [NUM_LANE-1:0] w_lane_vld;
    logic [c_SRC_W-1:0]  w_lane_src [NUM_LANE];
    logic                w_any;
    logic [c_SRC_W-1:0]  w_last;
    logic [c_SRC_W:0]    w_scan_sum;
    logic [c_SRC_W-1:0]  w_scan_idx;
    logic [c_NG_W-1:0]   w_scan_cnt;

    logic [c_SRC_W-1:0]  r_rr_ptr;
    logic [NUM_LANE-1:0] r_cdb_vld;
    logic [NUM_LANE-1:0] r_cdb_wr;
    logic [5:0]          r_cdb_pd  [NUM_LANE];
    logic [31:0]         r_cdb_res [NUM_LANE];

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic               r_wr_mem  [FIFO_DEPTH];
            logic [5:0]         r_pd_mem  [FIFO_DEPTH];
            logic [31:0]        r_res_mem [FIFO_DEPTH];
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_CNT_W-1:0] r_cnt;

            // Ready comes from the registered count only, so a full FIFO
            // refuses a push even in a cycle where it is also popped.
            assign bus.ready_src[i] = (r_cnt < c_CNT_W'(FIFO_DEPTH));
            assign w_push[i]        = bus.valid_src[i] && bus.ready_src[i];
            assign w_nonempty[i]    = (r_cnt != '0);
            assign w_head_wr[i]     = r_wr_mem[r_rd_ptr];
            assign w_head_pd[i]     = r_pd_mem[r_rd_ptr];
            assign w_head_res[i]    = r_res_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (rst || bus.flush) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wr_mem[r_wr_ptr]  <= bus.RegWr_src[i];
                        r_pd_mem[r_wr_ptr]  <= bus.Pd_src[i];
                        r_res_mem[r_wr_ptr] <= bus.Result_src[i];
                        r_wr_ptr            <= f_ptr_inc(r_wr_ptr);
                    end
                    if (w_grant[i]) begin
                        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                    end
                    if (w_push[i] && !w_grant[i]) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end else if (!w_push[i] && w_grant[i]) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // Scan from the round-robin pointer and pack grants into lanes 0,1,2...
    always_comb begin
        w_grant    = '0;
        w_lane_vld = '0;
        w_any      = 1'b0;
        w_last     = '0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        w_scan_cnt = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            w_lane_src[l] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (c_SRC_W + 1)'(k);
            if (w_scan_sum >= (c_SRC_W + 1)'(NUM_SRC)) begin
                w_scan_sum = w_scan_sum - (c_SRC_W + 1)'(NUM_SRC);
            end
            w_scan_idx = w_scan_sum[c_SRC_W-1:0];
            if (w_nonempty[w_scan_idx] && (w_scan_cnt < c_NG_W'(NUM_LANE))) begin
                w_grant[w_scan_idx]                     = 1'b1;
                w_lane_vld[w_scan_cnt[c_LIDX_W-1:0]]    = 1'b1;
                w_lane_src[w_scan_cnt[c_LIDX_W-1:0]]    = w_scan_idx;
                w_last                                  = w_scan_idx;
                w_any                                   = 1'b1;
                w_scan_cnt                              = w_scan_cnt + c_NG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_last == c_SRC_W'(NUM_SRC - 1)) ? '0 : w_last + c_SRC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_cdb_vld <= '0;
            r_cdb_wr  <= '0;
            for (int l = 0; l < NUM_LANE; l++) begin
                r_cdb_pd[l]  <= '0;
                r_cdb_res[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANE; l++) begin
                if (w_lane_vld[l]) begin
                    r_cdb_vld[l] <= 1'b1;
                    r_cdb_wr[l]  <= w_head_wr[w_lane_src[l]];
                    r_cdb_pd[l]  <= w_head_pd[w_lane_src[l]];
                    r_cdb_res[l] <= w_head_res[w_lane_src[l]];
                end else begin
                    r_cdb_vld[l] <= 1'b0;
                    r_cdb_wr[l]  <= 1'b0;
                    r_cdb_pd[l]  <= '0;
                    r_cdb_res[l] <= '0;
                end
            end
        end
    end

    assign bus.ready_cdb = r_cdb_vld;
    assign bus.RegWr_cdb = r_cdb_wr;

    generate
        for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
            assign bus.Pd_cdb[l]     = r_cdb_pd[l];
            assign bus.Result_cdb[l] = r_cdb_res[l];
        end
    endgenerate
endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Writeback arbiter directly upstream of the physical register file. It collects results from the execution units (alu, mdu, lsu, bru, csr, agu) and drives the NUM_LANE-lane common data bus that the PRF, issue queues and ROB consume.
- Each source has a small result FIFO with a valid/ready handshake. Each cycle a round-robin arbiter grants up to NUM_LANE non-empty FIFOs onto registered CDB lanes.

Parameters:
- NUM_SRC, 6, number of result sources (fixed order: 0 alu, 1 mdu, 2 lsu, 3 bru, 4 csr, 5 agu).
- NUM_LANE, 5, number of CDB lanes; must be ≤ NUM_SRC.
- FIFO_DEPTH, 2, entries per source FIFO; must be ≥ 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush from branch/exception recovery.
- valid_src[NUM_SRC-1:0]  input  1 each  source i offers a result.
- RegWr_src[NUM_SRC-1:0]  input  1 each  result writes a register.
- Pd_src[NUM_SRC-1:0]  input  6 each  destination physical register.
- Result_src[NUM_SRC-1:0]  input  32 each  result data.
- ready_src[NUM_SRC-1:0]  output  1 each  source i FIFO can accept.
- ready_cdb[NUM_LANE-1:0]  output  1 each  lane carries a valid result.
- RegWr_cdb[NUM_LANE-1:0]  output  1 each  lane register-write flag.
- Pd_cdb[NUM_LANE-1:0]  output  6 each  lane destination.
- Result_cdb[NUM_LANE-1:0]  output  32 each  lane data.

Behaviour:
- Reset (rst=1 at posedge):
  - All FIFOs are emptied and rr_ptr=0.
  - All CDB outputs go to 0, and ready_src goes to all-1 from the next cycle.
  - Reset overrides flush and push in the same cycle. Reset mid-operation discards every in-flight result.
- Handshake:
  - A push occurs when valid_src[i] && ready_src[i] at posedge.
  - ready_src[i] = (count_i < FIFO_DEPTH) and is derived from the registered count only. A full FIFO deasserts ready even if it pops in the same cycle.
  - valid without ready is a no-op; the source must hold its data.
- Arbitration, combinational from the registered FIFO heads:
  - Scan sources in order rr_ptr, rr_ptr+1, …, wrapping modulo NUM_SRC.
  - Grant the first min(NUM_LANE, #non-empty) non-empty sources.
  - The k-th granted source fills lane k. Lanes are packed from 0 with no gaps.
- Pop and output: at posedge each granted FIFO pops its head into the lane registers.
  - Granted lanes: ready_cdb=1, with RegWr/Pd/Result copied from the head.
  - Ungranted lanes: ready_cdb=0 and RegWr_cdb/Pd_cdb/Result_cdb=0.
- rr_ptr update:
  - If any grant occurred, rr_ptr becomes (last granted source + 1) mod NUM_SRC.
  - Otherwise rr_ptr is unchanged.
  - When fewer than NUM_LANE sources are non-empty, every one of them is granted.
- Latency:
  - A result pushed at edge N appears on the CDB during the cycle after edge N+1 (two-edge latency, no bypass).
  - Each CDB lane is valid for exactly one cycle per result.
- FIFO:
  - Circular buffer with wrap-around pointers; push and pop in the same cycle are allowed when not full.
  - Per-source order is preserved.
  - count never exceeds FIFO_DEPTH and never goes below 0.
- Flush (flush=1, rst=0, at posedge):
  - All FIFOs are emptied and rr_ptr=0.
  - All ready_cdb are cleared.
  - Pushes and pops in that cycle are discarded.
- Pass-through:
  - RegWr=0 results and Pd=0 results are still broadcast; the downstream PRF ignores Pd=0 writes.
  - Duplicate Pd across lanes is excluded by rename and is not checked.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valid_src=0 → ready_src=6'b111111 and all ready_cdb=0 for 10 cycles.
- Single result, latency: alu pushes Pd=6'd12, Result=32'hDEADBEEF, RegWr=1 at edge N → lane0 shows ready_cdb=1, Pd=12, Result=DEADBEEF in the cycle after edge N+1 only; lanes 1–4 stay 0.
- Over-subscription and fairness: all 6 sources push once with Pd=1..6 at edge N, rr_ptr=0.
  - After edge N+1: lanes 0–4 carry Pd=1..5 and rr_ptr=5.
  - After edge N+2: lane0 carries Pd=6 and the other lanes are idle.
- Backpressure: mdu pushes every cycle while a stub holds its grant off (the other 5 sources continuously non-empty) → ready_src[1] drops to 0 after 2 accepted pushes. Data then emerges in push order with no loss or duplication.
- Flush mid-operation: 3 FIFOs hold 2 entries each and flush=1 with valid_src[0]=1 → next cycle all ready_cdb=0, count=0 everywhere, and the flushed push is never seen on the CDB.
- Reset priority: rst=1 and flush=1 together while FIFOs are full → identical to reset. The first new push afterwards appears on lane0 with 2-edge latency.
